// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: scan sequencer for a multiplexed 4-digit 7-segment display.
// Each enabled digit gets a BLANK gap (digit_oe low) followed by a SHOW dwell
// (digit_oe high). Masked digits are skipped. Digit values are double
// buffered: loads land in a pending register and reach the shadow register
// only at frame boundaries or while idle, so a frame never shows mixed data.
//
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   scan_en         - 1 runs the scan, 0 goes idle with the display blanked
//   digit_mask[3:0] - bit i set means digit i is scanned
//   load            - single-cycle strobe capturing digit_data_in
//   digit_data_in   - four nibbles, digit i in bits [4i+3:4i]
//   load_ack        - one-cycle pulse when pending data moves to the shadow
//   digit_sel[1:0]  - index of the active digit
//   digit_oe        - active-high digit output enable (high only in SHOW)
//   nibble_out[3:0] - shadow nibble for digit_sel, one cycle behind
//   frame_start     - one-cycle pulse at each frame boundary
module digit_scan_ctrl #(
   parameter int unsigned DWELL_CYCLES = 65536,
   parameter int unsigned BLANK_CYCLES = 64,
   parameter int unsigned CNT_W        = 17
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan_en,
   input  logic [3:0]  digit_mask,
   input  logic        load,
   input  logic [15:0] digit_data_in,
   output logic        load_ack,
   output logic [1:0]  digit_sel,
   output logic        digit_oe,
   output logic [3:0]  nibble_out,
   output logic        frame_start
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned NIB_W  = 4;

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SEL_W-1:0]  digit_sel_q, digit_sel_d;
   logic              digit_oe_q, digit_oe_d;
   logic [NIB_W-1:0]  nibble_out_q, nibble_out_d;
   logic              load_ack_q, load_ack_d;
   logic              frame_start_q, frame_start_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic [DATA_W-1:0] pending_q, pending_d;
   logic              pend_valid_q, pend_valid_d;

   logic              mask_any;
   logic              blank_done;
   logic              dwell_done;
   logic              start;
   logic              advance;
   logic              boundary;
   logic              xfer;
   logic [SEL_W-1:0]  next_idx;
   logic [SEL_W-1:0]  low_idx;

   // First enabled digit after cur, wrapping 3->0; may return cur itself.
   function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                      input logic [3:0]       mask);
      logic [SEL_W-1:0] idx;
      logic [SEL_W-1:0] res;
      logic             found;
      res   = cur;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = SEL_W'(32'(cur) + k);
         if (!found && mask[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   // Lowest enabled digit index (0 when the mask is empty).
   function automatic logic [SEL_W-1:0] lowest_enabled(input logic [3:0] mask);
      logic [SEL_W-1:0] res;
      res = '0;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i]) res = SEL_W'(i);
      end
      return res;
   endfunction

   assign mask_any   = |digit_mask;
   assign blank_done = (cnt_q == BLANK_LAST);
   assign dwell_done = (cnt_q == DWELL_LAST);
   assign next_idx   = next_enabled(digit_sel_q, digit_mask);
   assign low_idx    = lowest_enabled(digit_mask);
   assign boundary   = (next_idx <= digit_sel_q);

   assign start      = scan_en && (state_q == IDLE) && mask_any;
   assign advance    = scan_en && (state_q == SHOW) && dwell_done && mask_any;
   // Shadow update: any idle cycle, or an advance that wraps the frame.
   assign xfer       = pend_valid_q && ((state_q == IDLE) || (advance && boundary));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; scan_en low forces IDLE from anywhere.
   always_comb begin
      state_d = state_q;
      if (!scan_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (mask_any)   state_d = BLANK;
            BLANK:   if (blank_done) state_d = SHOW;
            SHOW:    if (dwell_done) state_d = mask_any ? BLANK : IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and registered-output next values.
   always_comb begin
      cnt_d         = '0;
      digit_sel_d   = digit_sel_q;
      digit_oe_d    = (state_d == SHOW);
      nibble_out_d  = shadow_q[{digit_sel_q, 2'b00} +: NIB_W];
      frame_start_d = start || (advance && boundary);
      load_ack_d    = xfer;
      shadow_d      = shadow_q;
      pending_d     = pending_q;
      pend_valid_d  = pend_valid_q;

      // Phase counter restarts on every state change and rests in IDLE.
      if ((state_d == state_q) && (state_q != IDLE))
         cnt_d = CNT_W'(cnt_q + 1'b1);

      if (start)        digit_sel_d = low_idx;
      else if (advance) digit_sel_d = next_idx;

      // Transfer takes the old pending value; a same-cycle load stays pending.
      if (xfer) begin
         shadow_d     = pending_q;
         pend_valid_d = 1'b0;
      end
      if (load) begin
         pending_d    = digit_data_in;
         pend_valid_d = 1'b1;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         digit_sel_q   <= '0;
         digit_oe_q    <= 1'b0;
         nibble_out_q  <= '0;
         load_ack_q    <= 1'b0;
         frame_start_q <= 1'b0;
         shadow_q      <= '0;
         pending_q     <= '0;
         pend_valid_q  <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         digit_sel_q   <= digit_sel_d;
         digit_oe_q    <= digit_oe_d;
         nibble_out_q  <= nibble_out_d;
         load_ack_q    <= load_ack_d;
         frame_start_q <= frame_start_d;
         shadow_q      <= shadow_d;
         pending_q     <= pending_d;
         pend_valid_q  <= pend_valid_d;
      end
   end

   assign load_ack    = load_ack_q;
   assign digit_sel   = digit_sel_q;
   assign digit_oe    = digit_oe_q;
   assign nibble_out  = nibble_out_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with DWELL_CYCLES=8, BLANK_CYCLES=2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_digit_scan_ctrl;

   logic        clk;
   logic        rst;
   logic        scan_en;
   logic [3:0]  digit_mask;
   logic        load;
   logic [15:0] digit_data_in;
   logic        load_ack;
   logic [1:0]  digit_sel;
   logic        digit_oe;
   logic [3:0]  nibble_out;
   logic        frame_start;

   int n_pass  = 0;
   int n_total = 0;

   digit_scan_ctrl #(
      .DWELL_CYCLES (8),
      .BLANK_CYCLES (2),
      .CNT_W        (17)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .scan_en       (scan_en),
      .digit_mask    (digit_mask),
      .load          (load),
      .digit_data_in (digit_data_in),
      .load_ack      (load_ack),
      .digit_sel     (digit_sel),
      .digit_oe      (digit_oe),
      .nibble_out    (nibble_out),
      .frame_start   (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_sel"},   16'(digit_sel),   16'(0));
      chk({tag, "_oe"},    16'(digit_oe),    16'(0));
      chk({tag, "_nib"},   16'(nibble_out),  16'(0));
      chk({tag, "_ack"},   16'(load_ack),    16'(0));
      chk({tag, "_frame"}, 16'(frame_start), 16'(0));
   endtask

   // Called at the sample point right after the edge that entered BLANK for
   // digit es; returns at the sample point after that digit's final SHOW edge.
   // act: 1 = load val mid-SHOW, 2 = load val on the final edge,
   //      3 = clear digit_mask mid-SHOW.
   task automatic check_digit(input logic [1:0] es, input logic [3:0] en,
                              input logic efs, input logic eack,
                              input int act, input logic [15:0] val);
      chk("sel_at_advance", 16'(digit_sel),   16'(es));
      chk("oe_blank0",      16'(digit_oe),    16'(0));
      chk("frame_start",    16'(frame_start), 16'(efs));
      chk("load_ack",       16'(load_ack),    16'(eack));
      tick();
      chk("oe_blank1",      16'(digit_oe),    16'(0));
      chk("nibble",         16'(nibble_out),  16'(en));
      chk("frame_low",      16'(frame_start), 16'(0));
      chk("ack_low",        16'(load_ack),    16'(0));
      for (int i = 0; i < 8; i++) begin
         if (i == 2 && act == 1) begin
            load          = 1'b1;
            digit_data_in = val;
         end
         if (i == 2 && act == 3) digit_mask = 4'b0000;
         tick();
         load = 1'b0;
         chk("oe_show",       16'(digit_oe),  16'(1));
         chk("sel_show",      16'(digit_sel), 16'(es));
         chk("ack_show",      16'(load_ack),  16'(0));
      end
      if (act == 2) begin
         load          = 1'b1;
         digit_data_in = val;
      end
      tick();
      load = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      scan_en       = 1'b0;
      digit_mask    = 4'b0000;
      load          = 1'b0;
      digit_data_in = 16'h0000;
      repeat (3) tick();
      chk_reset_outputs("reset");

      // Load while idle: acknowledged on the following idle cycle.
      rst           = 1'b0;
      load          = 1'b1;
      digit_data_in = 16'h4321;
      tick();
      load = 1'b0;
      chk("idle_ack_before", 16'(load_ack), 16'(0));
      tick();
      chk("idle_ack_pulse",  16'(load_ack), 16'(1));
      tick();
      chk("idle_ack_after",  16'(load_ack), 16'(0));

      // Full scan, mask 1111.
      scan_en    = 1'b1;
      digit_mask = 4'b1111;
      tick();
      check_digit(2'd0, 4'h1, 1'b1, 1'b0, 0, 16'h0);
      check_digit(2'd1, 4'h2, 1'b0, 1'b0, 0, 16'h0);
      check_digit(2'd2, 4'h3, 1'b0, 1'b0, 0, 16'h0);
      check_digit(2'd3, 4'h4, 1'b0, 1'b0, 0, 16'h0);

      // Mask 0101 takes effect at the end of digit 0.
      digit_mask = 4'b0101;
      check_digit(2'd0, 4'h1, 1'b1, 1'b0, 0, 16'h0);
      check_digit(2'd2, 4'h3, 1'b0, 1'b0, 0, 16'h0);
      check_digit(2'd0, 4'h1, 1'b1, 1'b0, 0, 16'h0);
      check_digit(2'd2, 4'h3, 1'b0, 1'b0, 0, 16'h0);

      // Two loads within a frame: latest wins, one ack at the boundary.
      digit_mask = 4'b1111;
      check_digit(2'd0, 4'h1, 1'b1, 1'b0, 0, 16'h0);
      check_digit(2'd1, 4'h2, 1'b0, 1'b0, 1, 16'hAAAA);
      check_digit(2'd2, 4'h3, 1'b0, 1'b0, 1, 16'hBBBB);
      check_digit(2'd3, 4'h4, 1'b0, 1'b0, 0, 16'h0);
      check_digit(2'd0, 4'hB, 1'b1, 1'b1, 0, 16'h0);
      check_digit(2'd1, 4'hB, 1'b0, 1'b0, 0, 16'h0);

      // Load on the boundary edge while 0x1111 is pending.
      check_digit(2'd2, 4'hB, 1'b0, 1'b0, 1, 16'h1111);
      check_digit(2'd3, 4'hB, 1'b0, 1'b0, 2, 16'h2222);
      check_digit(2'd0, 4'h1, 1'b1, 1'b1, 0, 16'h0);
      check_digit(2'd1, 4'h1, 1'b0, 1'b0, 0, 16'h0);
      check_digit(2'd2, 4'h1, 1'b0, 1'b0, 0, 16'h0);
      check_digit(2'd3, 4'h1, 1'b0, 1'b0, 0, 16'h0);
      check_digit(2'd0, 4'h2, 1'b1, 1'b1, 0, 16'h0);

      // scan_en dropped mid-SHOW of digit 1.
      repeat (4) tick();
      chk("pre_drop_oe", 16'(digit_oe), 16'(1));
      scan_en = 1'b0;
      tick();
      chk("drop_oe",  16'(digit_oe),   16'(0));
      chk("drop_sel", 16'(digit_sel),  16'(1));
      chk("drop_nib", 16'(nibble_out), 16'(2));
      tick();
      chk("idle_oe",  16'(digit_oe),   16'(0));
      scan_en = 1'b1;
      tick();
      check_digit(2'd0, 4'h2, 1'b1, 1'b0, 0, 16'h0);
      check_digit(2'd1, 4'h2, 1'b0, 1'b0, 0, 16'h0);

      // Mask cleared mid-SHOW of digit 2: dwell completes, then IDLE.
      check_digit(2'd2, 4'h2, 1'b0, 1'b0, 3, 16'h0);
      chk("mask0_oe",    16'(digit_oe),    16'(0));
      chk("mask0_sel",   16'(digit_sel),   16'(2));
      chk("mask0_frame", 16'(frame_start), 16'(0));
      repeat (2) tick();
      chk("mask0_idle_oe", 16'(digit_oe), 16'(0));

      // Reset mid-BLANK with a pending load.
      digit_mask    = 4'b1111;
      load          = 1'b1;
      digit_data_in = 16'h9999;
      tick();
      load = 1'b0;
      chk("rb_frame", 16'(frame_start), 16'(1));
      chk("rb_oe",    16'(digit_oe),    16'(0));
      chk("rb_ack",   16'(load_ack),    16'(0));
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      scan_en    = 1'b0;
      digit_mask = 4'b0000;
      chk_reset_outputs("midrst");
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("discard_ack", 16'(load_ack), 16'(0));
      end

      // Restart after reset: shadow cleared, then a single enabled digit.
      scan_en    = 1'b1;
      digit_mask = 4'b1111;
      tick();
      digit_mask = 4'b1000;
      check_digit(2'd0, 4'h0, 1'b1, 1'b0, 0, 16'h0);
      check_digit(2'd3, 4'h0, 1'b0, 1'b0, 0, 16'h0);
      check_digit(2'd3, 4'h0, 1'b1, 1'b0, 0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
